// File: rtl/fpu_fma_wb_queue_pkg.sv
// rtl/fpu_fma_wb_queue_pkg.sv - shared FPU widths, pipe depths and helpers for the FMA writeback queue
//
// Purpose: common FPU definitions used by the writeback stage.
// The macros below mirror the FPU common include, so that legacy code using
// `FPR_RECODED_WIDTH, `FPU_EXC_WIDTH, `FPU_TAG_WIDTH and `FPU_PIPE_DEPTH(...)
// keeps working. The package gives typed equivalents to SystemVerilog users.
// Ports: none (package).

`ifndef FPU_COMMON_DEFS
`define FPU_COMMON_DEFS
`define FPR_RECODED_WIDTH 65
`define FPU_EXC_WIDTH 5
`define FPU_TAG_WIDTH 5
`define FPU_PIPE_FMA_S 0
`define FPU_PIPE_FMA_D 1
// Pipe depth of each FPU unit, selected by its unit id.
`define FPU_PIPE_DEPTH(unit) (((unit) == `FPU_PIPE_FMA_S) ? 4 : 5)
`endif

package fpu_fma_wb_queue_pkg;

  localparam int FPR_W = `FPR_RECODED_WIDTH;
  localparam int EXC_W = `FPU_EXC_WIDTH;

  // Population count of up to 32 valid bits.
  function automatic logic [31:0] count_ones(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_fma_wb_queue_fifo.sv
// rtl/fpu_fma_wb_queue_fifo.sv - width x depth synchronous circular FIFO (fpu_wb_fifo)
//
// Purpose: result buffer between the FMA pipe capture point and the FPR port.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push, push_data write an entry (ignored when full unless popping too)
//   pop             remove the head (ignored when empty)
//   head_data       current head entry, stable until popped
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags

module fpu_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fpu_fma_wb_queue.sv
// rtl/fpu_fma_wb_queue.sv - FMA writeback stage: valid/tag delay line, result FIFO, issue credits, sticky fflags
//
// Purpose: tracks ops through the stall-free FMA pipe, captures their results,
// buffers them and drains them to the FPR write port in issue order.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   issue_val/issue_rdy/issue_tag   op issue into the FMA pipe, credit-throttled
//   pipe_result/pipe_exc        FMA pipe output, meaningful only for tracked ops
//   wb_val/wb_rdy/wb_tag/wb_data/wb_exc   FIFO head toward the FPR write port
//   fflags_clr/fflags           sticky exception flags of retired results
//   busy                        an op is in flight or queued

module fpu_fma_wb_queue
  import fpu_fma_wb_queue_pkg::*;
#(
  parameter int LATENCY = `FPU_PIPE_DEPTH(`FPU_PIPE_FMA_S),
  parameter int QDEPTH  = 4,
  parameter int TAG_W   = `FPU_TAG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_val,
  output logic             issue_rdy,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [FPR_W-1:0] pipe_result,
  input  logic [EXC_W-1:0] pipe_exc,
  output logic             wb_val,
  input  logic             wb_rdy,
  output logic [TAG_W-1:0] wb_tag,
  output logic [FPR_W-1:0] wb_data,
  output logic [EXC_W-1:0] wb_exc,
  input  logic             fflags_clr,
  output logic [EXC_W-1:0] fflags,
  output logic             busy
);

  localparam int ENTRY_W = TAG_W + FPR_W + EXC_W;
  localparam int CNT_W   = $clog2(QDEPTH + 1);

  logic [LATENCY-1:0] dl_val;
  logic [TAG_W-1:0]   dl_tag [LATENCY];
  logic [31:0]        inflight;
  logic               issue_fire;
  logic               capture;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;

  assign issue_fire = issue_val & issue_rdy;

  // Valid bits shadow the FMA pipe stage by stage; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dl_val <= '0;
    end else begin
      dl_val[0] <= issue_fire;
      for (int k = 1; k < LATENCY; k++) begin
        dl_val[k] <= dl_val[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_tag[0] <= issue_tag;
    for (int k = 1; k < LATENCY; k++) begin
      dl_tag[k] <= dl_tag[k-1];
    end
  end

  // Every op holds one credit from issue until its result leaves the FIFO,
  // so a capture can never meet a full FIFO. Only registered state feeds this.
  assign inflight  = count_ones(32'(dl_val));
  assign issue_rdy = reset & ((inflight + 32'(fifo_count)) < 32'(QDEPTH));

  assign capture   = dl_val[LATENCY-1];
  assign fifo_push = capture & (~fifo_full | fifo_pop);
  assign fifo_pop  = wb_val & wb_rdy;

  fpu_wb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({dl_tag[LATENCY-1], pipe_result, pipe_exc}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wb_val = ~fifo_empty;
  assign {wb_tag, wb_data, wb_exc} = fifo_head;

  // A clear and a pop in the same cycle leave exactly the popped flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fflags <= '0;
    end else begin
      fflags <= (fflags_clr ? '0 : fflags) | (fifo_pop ? wb_exc : '0);
    end
  end

  assign busy = (inflight != 32'd0) | (fifo_count != '0);

endmodule
